// File: rtl/apb4_slave_regs.sv
// rtl/apb4_slave_regs.sv - APB4 register-file slave with byte strobes, wait states and error response
module apb4_slave_regs #(
    parameter int DATASIZE    = 32,
    parameter int ADDRSIZE    = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDRSIZE-1:0]   PADDR,
    input  logic [DATASIZE-1:0]   PWDATA,
    input  logic [DATASIZE/8-1:0] PSTRB,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    output logic [DATASIZE-1:0]   PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);
    localparam int NB = DATASIZE / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t              state, state_d;
    logic [3:0]          cnt, cnt_d;
    logic [AW-1:0]       idx_q, dec_idx, acc_idx;
    logic                err_q, wr_q, dec_err, acc_err, acc_wr;
    logic                lo_err, hi_err, range_err, ro_err;
    logic                setup, wr_commit;
    logic                pready_d, pslverr_d;
    logic [DATASIZE-1:0] prdata_d;
    logic [DATASIZE-1:0] mem [DEPTH];

    // Address decode of the live bus, used at the edge that ends the setup phase
    assign dec_idx = PADDR[AW+LB-1:LB];

    generate
        if (LB > 0) begin : g_lo
            assign lo_err = |PADDR[LB-1:0];
        end else begin : g_no_lo
            assign lo_err = 1'b0;
        end
        if (AW + LB < ADDRSIZE) begin : g_hi
            assign hi_err = |PADDR[ADDRSIZE-1:AW+LB];
        end else begin : g_no_hi
            assign hi_err = 1'b0;
        end
        // Only a non-power-of-two depth leaves index codes without a backing word
        if (DEPTH < (1 << AW)) begin : g_range
            assign range_err = ({1'b0, dec_idx} >= DEPTH[AW:0]);
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
        if (RO_WORDS > 0) begin : g_ro
            assign ro_err = PWRITE & ({1'b0, dec_idx} < RO_WORDS[AW:0]);
        end else begin : g_no_ro
            assign ro_err = 1'b0;
        end
    endgenerate

    assign dec_err   = lo_err | hi_err | range_err | ro_err;
    assign setup     = PSEL & ~PENABLE;
    // With zero wait states DONE is entered straight from IDLE, before the latch holds the decode
    assign acc_idx   = (state == ST_IDLE) ? dec_idx : idx_q;
    assign acc_err   = (state == ST_IDLE) ? dec_err : err_q;
    assign acc_wr    = (state == ST_IDLE) ? PWRITE  : wr_q;
    assign wr_commit = (state == ST_DONE) & PSEL & PENABLE & PWRITE & ~err_q;

    // State, wait counter and registered bus outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            PRDATA  <= prdata_d;
        end
    end

    // Next state and the output values presented while in DONE
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    if (WAIT_LD == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - 4'd1;
                    if (cnt == 4'd1) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_DONE) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            if (!acc_err && !acc_wr) prdata_d = mem[acc_idx];
        end
    end

    // Capture the transfer's decode when the setup phase ends
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q <= '0;
            err_q <= 1'b0;
            wr_q  <= 1'b0;
        end else if (state == ST_IDLE && setup) begin
            idx_q <= dec_idx;
            err_q <= dec_err;
            wr_q  <= PWRITE;
        end
    end

    // Register array: byte-lane write at the edge that ends DONE
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (PSTRB[i]) mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb4_slave_regs.sv
// tb/tb_apb4_slave_regs.sv - self-checking bench for apb4_slave_regs (zero-wait and 3-wait instances)
module tb_apb4_slave_regs;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic        psel [2];
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [2][16];
    int          ro_m [2] = '{2, 0};
    int          wt_m [2] = '{0, 3};
    logic [31:0] last_rd;
    time         last_done;

    always #5 PCLK = ~PCLK;

    apb4_slave_regs #(.DATASIZE(32), .ADDRSIZE(32), .DEPTH(16), .WAIT_CYCLES(0), .RO_WORDS(2)) u_w0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb4_slave_regs #(.DATASIZE(32), .ADDRSIZE(32), .DEPTH(16), .WAIT_CYCLES(3), .RO_WORDS(0)) u_w3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input int d, input bit wr, input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 16) || (wr && (a / 4) < ro_m[d]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] mask;
        mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    task automatic clear_models();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) mem_m[d][w] = '0;
    endtask

    task automatic setup_phase(input int d, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st);
        @(posedge PCLK); #1;
        psel[0] = (d == 0);
        psel[1] = (d == 1);
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        PSTRB   = st;
    endtask

    task automatic access_phase();
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
    endtask

    task automatic wait_ready(input int d, output int waits, output bit to);
        waits = 0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (pready[d] === 1'b1) begin
                to = 1'b0;
                break;
            end
            waits++;
        end
        last_done = $time;
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_pready"}, pready[d], 0);
            chk({tag, "_prdata"}, prdata[d], 0);
            chk({tag, "_pslverr"}, pslverr[d], 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
            psel[0] = 1'b0;
            psel[1] = 1'b0;
            PENABLE = 1'b0;
            @(negedge PCLK);
            check_quiet("idle");
        end
    endtask

    task automatic apb(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input string tag);
        int          waits;
        bit          to;
        bit          e;
        logic [31:0] exp_rd;
        e = exp_err(d, wr, a);
        exp_rd = '0;
        if (!e && !wr) exp_rd = mem_m[d][a / 4];
        setup_phase(d, wr, a, wd, st);
        access_phase();
        wait_ready(d, waits, to);
        chk({tag, "_timeout"}, to, 0);
        chk({tag, "_waits"}, waits, wt_m[d]);
        chk({tag, "_pslverr"}, pslverr[d], e);
        if (!wr) chk({tag, "_prdata"}, prdata[d], exp_rd);
        last_rd = prdata[d];
        if (wr && !e) mem_m[d][a / 4] = merge(mem_m[d][a / 4], wd, st);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the end of the run");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        bit          to;
        time         t1;
        logic [31:0] a;
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        clear_models();

        // Reset state
        repeat (2) @(negedge PCLK);
        check_quiet("reset");
        @(posedge PCLK); #1 PRESETn = 1'b1;

        // Zero-wait read after reset
        apb(0, 1'b0, 32'h04, '0, 4'h0, "rd0_04");
        chk("rd0_04_zero", last_rd, 32'h0);

        // Strobed writes
        apb(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, "wr0_08a");
        apb(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, "wr0_08b");
        apb(0, 1'b0, 32'h08, '0, 4'h0, "rd0_08");
        chk("strobe_merge", last_rd, 32'hDE22BE44);
        apb(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, "wr0_nostrb");
        apb(0, 1'b0, 32'h08, '0, 4'h0, "rd0_08_nostrb");
        chk("nostrb_unchanged", last_rd, 32'hDE22BE44);
        idle(1);

        // Wait states: 3 low cycles and a 5-cycle transfer span
        apb(1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, "wr3_0c");
        t1 = last_done;
        apb(1, 1'b0, 32'h0C, '0, 4'h0, "rd3_0c");
        chk("span_cycles", (last_done - t1) / 10, 5);
        chk("rd3_0c_val", last_rd, 32'hCAFEF00D);
        idle(2);

        // Error responses
        apb(0, 1'b0, 32'h40, '0, 4'h0, "rd0_oob");
        apb(0, 1'b1, 32'h02, 32'h55555555, 4'hF, "wr0_unal");
        apb(0, 1'b0, 32'h00, '0, 4'h0, "rd0_00_after_unal");
        apb(0, 1'b1, 32'h04, 32'hAAAAAAAA, 4'hF, "wr0_ro");
        apb(0, 1'b0, 32'h04, '0, 4'h0, "rd0_04_after_ro");
        apb(1, 1'b0, 32'h0001_0008, '0, 4'h0, "rd3_hi");
        apb(1, 1'b1, 32'h0001_000C, 32'h12345678, 4'hF, "wr3_hi");
        apb(1, 1'b0, 32'h0C, '0, 4'h0, "rd3_0c_after_hi");
        idle(1);

        // Back-to-back writes then reads on both instances
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) apb(d, 1'b1, w * 4, $urandom, 4'hF, "b2b_wr");
            for (int w = 0; w < 8; w++) apb(d, 1'b0, w * 4, '0, 4'h0, "b2b_rd");
            idle(1);
        end

        // Abort by dropping PSEL during a wait cycle
        setup_phase(1, 1'b1, 32'h14, 32'h0BAD0BAD, 4'hF);
        access_phase();
        @(negedge PCLK);
        chk("abort_wait_pready", pready[1], 0);
        idle(3);
        apb(1, 1'b0, 32'h14, '0, 4'h0, "abort_rd");
        idle(1);

        // Async reset while DONE is presenting read data
        setup_phase(0, 1'b0, 32'h08, '0, 4'h0);
        access_phase();
        wait_ready(0, waits, to);
        chk("rstdone_ready", pready[0], 1);
        chk("rstdone_data", prdata[0], mem_m[0][2]);
        #2 PRESETn = 1'b0;
        #1;
        chk("rstdone_pready_async", pready[0], 0);
        chk("rstdone_prdata_async", prdata[0], 0);
        clear_models();
        @(posedge PCLK); #1 PRESETn = 1'b1;
        idle(1);
        apb(0, 1'b0, 32'h08, '0, 4'h0, "rd0_after_rst");

        // Async reset during a wait cycle of a write to 0x10
        apb(1, 1'b1, 32'h10, 32'h600DF00D, 4'hF, "wr3_10");
        setup_phase(1, 1'b1, 32'h10, 32'hFFFF0000, 4'hF);
        access_phase();
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        chk("rstwait_pready", pready[1], 0);
        chk("rstwait_prdata", prdata[1], 0);
        chk("rstwait_pslverr", pslverr[1], 0);
        clear_models();
        @(posedge PCLK); #1 PRESETn = 1'b1;
        idle(1);
        apb(1, 1'b0, 32'h10, '0, 4'h0, "rd3_10_after_rst");
        chk("rd3_10_zero", last_rd, 32'h0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 120; n++) begin
            int d;
            d = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:       a = 32'h8000_0000 | ($urandom_range(0, 15) * 4);
                1:       a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
                default: a = $urandom_range(0, 17) * 4;
            endcase
            apb(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
